// File: rtl/xbar_banks_pea_sel_seq.sv
// Select sequencer for one banks/PE-array crossbar basic block: replays a
// programmable table of (bank->PE, PE->bank) selects for n_iter passes.
module xbar_banks_pea_sel_seq #(
  parameter int N_BANKS_PER_BB = 4,
  parameter int N_PE_PER_BB    = 4,
  parameter int N_STEPS        = 8,
  parameter int ITER_W         = 16,
  localparam int LOG_NB = (N_BANKS_PER_BB > 1) ? $clog2(N_BANKS_PER_BB) : 1,
  localparam int LOG_NP = (N_PE_PER_BB > 1) ? $clog2(N_PE_PER_BB) : 1,
  localparam int LOG_NS = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cfg_we_i,
  input  logic [LOG_NS-1:0] cfg_addr_i,
  input  logic [LOG_NB-1:0] cfg_sel_dmem_pea_i,
  input  logic [LOG_NP-1:0] cfg_sel_pea_dmem_i,
  input  logic [LOG_NS-1:0] last_step_i,
  input  logic [ITER_W-1:0] n_iter_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [LOG_NB-1:0] sel_dmem_pea_bb_o,
  output logic [LOG_NP-1:0] sel_pea_dmem_bb_o,
  output logic [LOG_NS-1:0] step_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [LOG_NB-1:0] tab_dp_q [N_STEPS];
  logic [LOG_NP-1:0] tab_pd_q [N_STEPS];

  logic [LOG_NS-1:0] step_q, step_d;
  logic [LOG_NS-1:0] last_q, last_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] niter_q, niter_d;

  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [LOG_NB-1:0] sel_dp_q, sel_dp_d;
  logic [LOG_NP-1:0] sel_pd_q, sel_pd_d;
  logic [LOG_NS-1:0] step_out_q, step_out_d;

  logic              tab_we;
  logic              seq_end;
  logic              step_wrap;
  logic [LOG_NS-1:0] step_nxt;
  logic [LOG_NS-1:0] last_clamped;

  // Table is frozen whenever a sequence is in flight.
  assign tab_we = cfg_we_i && (state_q == IDLE) &&
                  ({1'b0, cfg_addr_i} < (LOG_NS + 1)'(N_STEPS));

  assign last_clamped = ({1'b0, last_step_i} > (LOG_NS + 1)'(N_STEPS - 1)) ?
                        LOG_NS'(N_STEPS - 1) : last_step_i;

  assign step_wrap = (step_q == last_q);
  assign step_nxt  = step_wrap ? '0 : step_q + LOG_NS'(1);
  assign seq_end   = step_wrap && (iter_q == niter_q - ITER_W'(1));

  generate
    for (genvar gi = 0; gi < N_STEPS; gi++) begin : g_tab
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          tab_dp_q[gi] <= '0;
          tab_pd_q[gi] <= '0;
        end else if (tab_we && (cfg_addr_i == LOG_NS'(gi))) begin
          tab_dp_q[gi] <= cfg_sel_dmem_pea_i;
          tab_pd_q[gi] <= cfg_sel_pea_dmem_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = (n_iter_i == '0) ? DONE : RUN;
        RUN:     if (!stall_i && seq_end) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    step_d     = step_q;
    iter_d     = iter_q;
    last_d     = last_q;
    niter_d    = niter_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    sel_dp_d   = sel_dp_q;
    sel_pd_d   = sel_pd_q;
    step_out_d = step_out_q;
    if (clear_i) begin
      step_d     = '0;
      iter_d     = '0;
      valid_d    = 1'b0;
      sel_dp_d   = '0;
      sel_pd_d   = '0;
      step_out_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_d = 1'b0;
          if (start_i) begin
            last_d  = last_clamped;
            niter_d = n_iter_i;
            step_d  = '0;
            iter_d  = '0;
            if (n_iter_i != '0) begin
              valid_d    = 1'b1;
              step_out_d = '0;
              // A same-cycle write to entry 0 must reach the first presentation.
              if (tab_we && (cfg_addr_i == '0)) begin
                sel_dp_d = cfg_sel_dmem_pea_i;
                sel_pd_d = cfg_sel_pea_dmem_i;
              end else begin
                sel_dp_d = tab_dp_q[0];
                sel_pd_d = tab_pd_q[0];
              end
            end else begin
              done_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (!stall_i) begin
            if (seq_end) begin
              valid_d = 1'b0;
              done_d  = 1'b1;
              step_d  = '0;
              iter_d  = '0;
            end else begin
              step_d     = step_nxt;
              iter_d     = step_wrap ? iter_q + ITER_W'(1) : iter_q;
              valid_d    = 1'b1;
              sel_dp_d   = tab_dp_q[step_nxt];
              sel_pd_d   = tab_pd_q[step_nxt];
              step_out_d = step_nxt;
            end
          end
        end
        DONE: begin
          valid_d = 1'b0;
        end
        default: begin
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      step_q     <= '0;
      iter_q     <= '0;
      last_q     <= '0;
      niter_q    <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      sel_dp_q   <= '0;
      sel_pd_q   <= '0;
      step_out_q <= '0;
    end else begin
      step_q     <= step_d;
      iter_q     <= iter_d;
      last_q     <= last_d;
      niter_q    <= niter_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      sel_dp_q   <= sel_dp_d;
      sel_pd_q   <= sel_pd_d;
      step_out_q <= step_out_d;
    end
  end

  assign busy_o            = (state_q != IDLE);
  assign valid_o           = valid_q;
  assign done_o            = done_q;
  assign sel_dmem_pea_bb_o = sel_dp_q;
  assign sel_pea_dmem_bb_o = sel_pd_q;
  assign step_o            = step_out_q;

endmodule

// File: tb/tb_xbar_banks_pea_sel_seq.sv
// Directed bench for xbar_banks_pea_sel_seq with hand-computed expectations.
module tb_xbar_banks_pea_sel_seq;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [1:0]  cfg_dp;
  logic [1:0]  cfg_pd;
  logic [2:0]  last_step;
  logic [15:0] n_iter;
  logic        start;
  logic        stall;
  logic        clear;
  logic        busy;
  logic        valid;
  logic [1:0]  sel_dp;
  logic [1:0]  sel_pd;
  logic [2:0]  step;
  logic        done;

  integer total = 0;
  integer bad   = 0;

  xbar_banks_pea_sel_seq dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .cfg_we_i           (cfg_we),
    .cfg_addr_i         (cfg_addr),
    .cfg_sel_dmem_pea_i (cfg_dp),
    .cfg_sel_pea_dmem_i (cfg_pd),
    .last_step_i        (last_step),
    .n_iter_i           (n_iter),
    .start_i            (start),
    .stall_i            (stall),
    .clear_i            (clear),
    .busy_o             (busy),
    .valid_o            (valid),
    .sel_dmem_pea_bb_o  (sel_dp),
    .sel_pea_dmem_bb_o  (sel_pd),
    .step_o             (step),
    .done_o             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; inputs are driven and outputs sampled 1ns after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [1:0] dp, input logic [1:0] pd);
    cfg_we = 1'b1; cfg_addr = a; cfg_dp = dp; cfg_pd = pd;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] dp,
                         input logic [1:0] pd, input logic [2:0] st);
    chk({tag, "_valid"}, 32'(valid), 32'(v));
    chk({tag, "_dp"}, 32'(sel_dp), 32'(dp));
    chk({tag, "_pd"}, 32'(sel_pd), 32'(pd));
    chk({tag, "_step"}, 32'(step), 32'(st));
  endtask

  initial begin
    int vcnt;
    bit seen_done;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_dp = '0; cfg_pd = '0;
    last_step = '0; n_iter = '0; start = 1'b0; stall = 1'b0; clear = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk_out("rst", 1'b0, 2'd0, 2'd0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Program entries 0..3 = (0,3),(1,2),(2,1),(3,0)
    for (int i = 0; i < 4; i++) wr(3'(i), 2'(i), 2'(3 - i));

    // Run A: last=3, n_iter=2 -> 8 valid cycles, then done, then idle
    last_step = 3'd3; n_iter = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_out($sformatf("A_k%0d", k), 1'b1, 2'(k % 4), 2'(3 - (k % 4)), 3'(k % 4));
      chk($sformatf("A_busy_k%0d", k), 32'(busy), 1);
      chk($sformatf("A_nodone_k%0d", k), 32'(done), 0);
      tick();
    end
    chk("A_done", 32'(done), 1);
    chk_out("A_donecyc", 1'b0, 2'd3, 2'd0, 3'd3);
    tick();
    chk("A_idle_busy", 32'(busy), 0);
    chk("A_idle_done", 32'(done), 0);

    // Run B: stall 3 cycles while step==1 -> 11 valid cycles total
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("B_s0", 1'b1, 2'd0, 2'd3, 3'd0);
    tick();
    chk_out("B_s1", 1'b1, 2'd1, 2'd2, 3'd1);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("B_stall%0d", k), 1'b1, 2'd1, 2'd2, 3'd1);
    end
    stall = 1'b0;
    vcnt = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      tick();
      if (valid) vcnt++;
      else begin
        chk("B_done_after_last", 32'(done), 1);
        seen_done = 1'b1;
      end
    end
    chk("B_terminated", 32'(seen_done), 1);
    chk("B_valid_total", 32'(vcnt + 5), 11);
    tick();

    // Run C: n_iter=0 -> no valid, done at t+1, idle at t+2
    n_iter = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("C_valid", 32'(valid), 0);
    chk("C_done", 32'(done), 1);
    chk("C_busy", 32'(busy), 1);
    tick();
    chk("C_idle", 32'(busy), 0);
    chk("C_done_off", 32'(done), 0);

    // Run D: clear during 3rd valid cycle, then restart from entry 0
    n_iter = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_out("D_third", 1'b1, 2'd2, 2'd1, 3'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("D_clr_valid", 32'(valid), 0);
    chk("D_clr_done", 32'(done), 0);
    chk("D_clr_busy", 32'(busy), 0);
    tick();
    chk("D_no_done", 32'(done), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("D_restart", 1'b1, 2'd0, 2'd3, 3'd0);
    tick();
    chk_out("D_restart1", 1'b1, 2'd1, 2'd2, 3'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Run E: write to entry 0 while busy is ignored
    n_iter = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wr(3'd0, 2'd3, 2'd3);
    for (int i = 0; i < 6; i++) tick();
    chk("E_idle", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("E_entry0", 1'b1, 2'd0, 2'd3, 3'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Simultaneous start and write to entry 0: new value presented first
    last_step = 3'd0; n_iter = 16'd1;
    start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_dp = 2'd2; cfg_pd = 2'd1;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    chk_out("W_bypass", 1'b1, 2'd2, 2'd1, 3'd0);
    tick();
    chk("W_done", 32'(done), 1);
    chk("W_done_nvalid", 32'(valid), 0);
    tick();

    // Run F: async reset mid-run, then one-step single pass on cleared table
    last_step = 3'd3; n_iter = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("F_rst_busy", 32'(busy), 0);
    chk_out("F_rst", 1'b0, 2'd0, 2'd0, 3'd0);
    tick();
    rst_n = 1'b1;
    tick();
    last_step = 3'd0; n_iter = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("F_one", 1'b1, 2'd0, 2'd0, 3'd0);
    tick();
    chk("F_done", 32'(done), 1);
    chk("F_done_nvalid", 32'(valid), 0);
    tick();
    chk("F_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
